// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel-coordinate and sync bundle from the raster generator
interface vga_timing_gen_if #(
  parameter int w_x = 10,
  parameter int w_y = 9
);
  logic           pixel_strobe;
  logic           hsync;
  logic           vsync;
  logic           display_on;
  logic [w_x-1:0] x;
  logic [w_y-1:0] y;
  logic           frame_start;

  modport master (
    output pixel_strobe, hsync, vsync, display_on, x, y, frame_start
  );

  modport slave (
    input pixel_strobe, hsync, vsync, display_on, x, y, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster counters with registered coordinate/sync decode
module vga_timing_gen #(
  parameter int clk_mhz       = 50,
  parameter int pixel_mhz     = 25,
  parameter int screen_width  = 640,
  parameter int screen_height = 480,
  parameter int h_front       = 16,
  parameter int h_sync        = 96,
  parameter int h_back        = 48,
  parameter int v_front       = 10,
  parameter int v_sync        = 2,
  parameter int v_back        = 33,
  parameter int w_x           = $clog2(screen_width),
  parameter int w_y           = $clog2(screen_height)
) (
  input  logic             clk,
  input  logic             rst,
  vga_timing_gen_if.master vga
);
  localparam int DIV     = clk_mhz / pixel_mhz;
  localparam int H_TOTAL = screen_width + h_front + h_sync + h_back;
  localparam int V_TOTAL = screen_height + v_front + v_sync + v_back;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS      = HW'(screen_width);
  localparam logic [VW-1:0] V_VIS      = VW'(screen_height);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(screen_width + h_front);
  localparam logic [HW-1:0] H_SYNC_END = HW'(screen_width + h_front + h_sync);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(screen_height + v_front);
  localparam logic [VW-1:0] V_SYNC_END = VW'(screen_height + v_front + v_sync);

  generate
    if ((DIV < 1) || (clk_mhz % pixel_mhz != 0)) begin : g_bad_div
      $error("vga_timing_gen: clk_mhz must be an integer multiple of pixel_mhz");
    end
  endgenerate

  logic [DW-1:0] div_cnt;
  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;
  logic          pix_en;
  logic          wrap_pend;

  assign pix_en = (div_cnt == DIV_LAST);

  // wrap_pend marks the wrap edge so frame_start fires only on a real frame wrap, never after reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt   <= '0;
      hpos      <= '0;
      vpos      <= '0;
      wrap_pend <= 1'b0;
    end else begin
      div_cnt   <= pix_en ? '0 : div_cnt + DW'(1);
      wrap_pend <= pix_en && (hpos == H_LAST) && (vpos == V_LAST);
      if (pix_en) begin
        if (hpos != H_LAST) begin
          hpos <= hpos + HW'(1);
        end else begin
          hpos <= '0;
          vpos <= (vpos == V_LAST) ? '0 : vpos + VW'(1);
        end
      end
    end
  end

  logic vis;
  logic hs_n;
  logic vs_n;

  always_comb begin
    vis  = (hpos < H_VIS) && (vpos < V_VIS);
    hs_n = !((hpos >= H_SYNC_BEG) && (hpos < H_SYNC_END));
    vs_n = !((vpos >= V_SYNC_BEG) && (vpos < V_SYNC_END));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vga.pixel_strobe <= 1'b0;
      vga.hsync        <= 1'b1;
      vga.vsync        <= 1'b1;
      vga.display_on   <= 1'b0;
      vga.x            <= '0;
      vga.y            <= '0;
      vga.frame_start  <= 1'b0;
    end else begin
      vga.pixel_strobe <= pix_en;
      vga.hsync        <= hs_n;
      vga.vsync        <= vs_n;
      vga.display_on   <= vis;
      vga.x            <= vis ? hpos[w_x-1:0] : '0;
      vga.y            <= vis ? vpos[w_y-1:0] : '0;
      vga.frame_start  <= wrap_pend;
    end
  end
endmodule
